// File: rtl/mmss_countdown_timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
package mmss_countdown_timer_pkg;

   // Timer control states
   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StRunning = 2'd1,
      StPaused  = 2'd2,
      StDone    = 2'd3
   } state_e;

   // Largest legal value of a BCD ones digit / seconds-tens digit
   localparam logic [3:0]  DIGIT_MAX_9 = 4'd9;
   localparam logic [3:0]  DIGIT_MAX_5 = 4'd5;

   // 00:00 and 00:01 in packed BCD
   localparam logic [15:0] BCD_ZERO    = 16'h0000;
   localparam logic [15:0] BCD_ONE     = 16'h0001;

   // Saturate one BCD digit at its limit
   function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
      return (d > lim) ? lim : d;
   endfunction

   // Force an arbitrary 16-bit value into a legal MM:SS BCD value
   function automatic logic [15:0] sanitise_bcd(input logic [15:0] v);
      return {clamp_digit(v[15:12], DIGIT_MAX_9),
              clamp_digit(v[11:8],  DIGIT_MAX_9),
              clamp_digit(v[7:4],   DIGIT_MAX_5),
              clamp_digit(v[3:0],   DIGIT_MAX_9)};
   endfunction

endpackage

// File: rtl/mmss_countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit that wraps 0 -> MAX and signals a borrow to the next digit.
module bcd_down_digit
   import mmss_countdown_timer_pkg::*;
#(
   parameter logic [3:0] MAX       = DIGIT_MAX_9,
   parameter logic [3:0] RESET_VAL = 4'd0
) (
   input  logic       i_clk,
   input  logic       i_clear,
   input  logic       i_en,
   input  logic       i_load,
   input  logic [3:0] i_load_val,
   output logic [3:0] o_q,
   output logic       o_borrow_out
);

   logic [3:0] r_q;

   // Load has priority over decrement; decrement wraps at zero
   always_ff @(posedge i_clk or posedge i_clear) begin
      if (i_clear) begin
         r_q <= RESET_VAL;
      end else if (i_load) begin
         r_q <= i_load_val;
      end else if (i_en) begin
         r_q <= (r_q == 4'd0) ? MAX : (r_q - 4'd1);
      end
   end

   // Borrow ripples combinationally so the whole count updates on one edge
   assign o_borrow_out = i_en && (r_q == 4'd0);
   assign o_q          = r_q;

endmodule

// File: rtl/mmss_countdown_timer.sv
// Four-digit BCD MM:SS countdown timer with start/pause/load control.
// Optional feature: define MMSS_TIMER_AUTO_RELOAD_EN to reload the count at expiry
// instead of stopping in DONE (unless the reload value is 00:00).
module mmss_countdown_timer
   import mmss_countdown_timer_pkg::*;
#(
   parameter logic [15:0] DEFAULT_LOAD = 16'h0100
) (
   input  logic        i_clk,
   input  logic        i_clear,
   input  logic        i_tick,
   input  logic        i_load,
   input  logic [15:0] i_load_value,
   input  logic        i_start,
   input  logic        i_pause,
   output logic [15:0] o_digits,
   output logic        o_running,
   output logic        o_done,
   output logic        o_done_pulse
);

   state_e      r_state;
   logic [15:0] r_reload;
   logic        r_running;
   logic        r_done;
   logic        r_done_pulse;

   logic [15:0] w_count;
   logic [15:0] w_sanitised;
   logic [15:0] w_digit_load_val;
   logic        w_dec;
   logic        w_expire;
   logic        w_reload_now;
   logic        w_digit_load;
   logic [2:0]  w_borrow;
   logic        w_unused_borrow;

   assign w_sanitised = sanitise_bcd(i_load_value);

   // A load in the same cycle suppresses the tick
   assign w_dec    = (r_state == StRunning) && i_tick && !i_load;
   assign w_expire = w_dec && (w_count == BCD_ONE);

`ifdef MMSS_TIMER_AUTO_RELOAD_EN
   assign w_reload_now = w_expire && (r_reload != BCD_ZERO);
`else
   assign w_reload_now = 1'b0;
`endif

   assign w_digit_load     = i_load || w_reload_now;
   assign w_digit_load_val = i_load ? w_sanitised : r_reload;

   bcd_down_digit #(
      .MAX       (DIGIT_MAX_9),
      .RESET_VAL (DEFAULT_LOAD[3:0])
   ) u_sec_ones (
      .i_clk        (i_clk),
      .i_clear      (i_clear),
      .i_en         (w_dec),
      .i_load       (w_digit_load),
      .i_load_val   (w_digit_load_val[3:0]),
      .o_q          (w_count[3:0]),
      .o_borrow_out (w_borrow[0])
   );

   bcd_down_digit #(
      .MAX       (DIGIT_MAX_5),
      .RESET_VAL (DEFAULT_LOAD[7:4])
   ) u_sec_tens (
      .i_clk        (i_clk),
      .i_clear      (i_clear),
      .i_en         (w_borrow[0]),
      .i_load       (w_digit_load),
      .i_load_val   (w_digit_load_val[7:4]),
      .o_q          (w_count[7:4]),
      .o_borrow_out (w_borrow[1])
   );

   bcd_down_digit #(
      .MAX       (DIGIT_MAX_9),
      .RESET_VAL (DEFAULT_LOAD[11:8])
   ) u_min_ones (
      .i_clk        (i_clk),
      .i_clear      (i_clear),
      .i_en         (w_borrow[1]),
      .i_load       (w_digit_load),
      .i_load_val   (w_digit_load_val[11:8]),
      .o_q          (w_count[11:8]),
      .o_borrow_out (w_borrow[2])
   );

   // Borrow out of the top digit cannot occur: RUNNING never holds 00:00
   bcd_down_digit #(
      .MAX       (DIGIT_MAX_9),
      .RESET_VAL (DEFAULT_LOAD[15:12])
   ) u_min_tens (
      .i_clk        (i_clk),
      .i_clear      (i_clear),
      .i_en         (w_borrow[2]),
      .i_load       (w_digit_load),
      .i_load_val   (w_digit_load_val[15:12]),
      .o_q          (w_count[15:12]),
      .o_borrow_out (w_unused_borrow)
   );

   // Reload register captures every sanitised load
   always_ff @(posedge i_clk or posedge i_clear) begin
      if (i_clear) begin
         r_reload <= DEFAULT_LOAD;
      end else if (i_load) begin
         r_reload <= w_sanitised;
      end
   end

   // Control FSM with registered status outputs
   always_ff @(posedge i_clk or posedge i_clear) begin
      if (i_clear) begin
         r_state      <= StIdle;
         r_running    <= 1'b0;
         r_done       <= 1'b0;
         r_done_pulse <= 1'b0;
      end else begin
         r_done_pulse <= 1'b0;
         if (i_load) begin
            r_state   <= StIdle;
            r_running <= 1'b0;
            r_done    <= 1'b0;
         end else begin
            unique case (r_state)
               StIdle, StPaused: begin
                  if (i_start) begin
                     if (w_count == BCD_ZERO) begin
                        r_state      <= StDone;
                        r_done       <= 1'b1;
                        r_done_pulse <= 1'b1;
                     end else begin
                        r_state   <= StRunning;
                        r_running <= 1'b1;
                     end
                  end
               end
               StRunning: begin
                  if (w_expire) begin
                     // Expiry outranks a simultaneous pause
                     r_done_pulse <= 1'b1;
                     if (!w_reload_now) begin
                        r_state   <= StDone;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                     end
                  end else if (i_pause && !i_start) begin
                     r_state   <= StPaused;
                     r_running <= 1'b0;
                  end
               end
               StDone: begin
                  r_state <= StDone;
               end
               default: begin
                  r_state   <= StIdle;
                  r_running <= 1'b0;
                  r_done    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_digits     = w_count;
   assign o_running    = r_running;
   assign o_done       = r_done;
   assign o_done_pulse = r_done_pulse;

endmodule

// File: tb/tb_mmss_countdown_timer.sv
// Self-checking bench for mmss_countdown_timer: directed cases plus randomized traffic
// compared every cycle against a seconds-based reference model.
module tb_mmss_countdown_timer;

   logic        clk = 1'b0;
   logic        clear;
   logic        tick;
   logic        load;
   logic [15:0] load_value;
   logic        start;
   logic        pause;
   logic [15:0] digits;
   logic        running;
   logic        done;
   logic        done_pulse;

   int checks = 0;
   int errors = 0;

`ifdef MMSS_TIMER_AUTO_RELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   // Reference model: count kept as total seconds
   int m_secs;
   int m_reload;
   int m_state;
   bit m_pulse;

   always #5 clk = ~clk;

   mmss_countdown_timer #(
      .DEFAULT_LOAD (16'h0100)
   ) dut (
      .i_clk        (clk),
      .i_clear      (clear),
      .i_tick       (tick),
      .i_load       (load),
      .i_load_value (load_value),
      .i_start      (start),
      .i_pause      (pause),
      .o_digits     (digits),
      .o_running    (running),
      .o_done       (done),
      .o_done_pulse (done_pulse)
   );

   function automatic int bcd_to_secs(input logic [15:0] v);
      int mt, mo, st, so;
      mt = int'(v[15:12]); if (mt > 9) mt = 9;
      mo = int'(v[11:8]);  if (mo > 9) mo = 9;
      st = int'(v[7:4]);   if (st > 5) st = 5;
      so = int'(v[3:0]);   if (so > 9) so = 9;
      return (mt * 10 + mo) * 60 + st * 10 + so;
   endfunction

   function automatic logic [15:0] secs_to_bcd(input int s);
      int m, ss;
      m  = s / 60;
      ss = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_secs   = bcd_to_secs(16'h0100);
      m_reload = m_secs;
      m_state  = M_IDLE;
      m_pulse  = 1'b0;
   endtask

   task automatic model_step(input bit t, input bit s, input bit p, input bit l,
                             input logic [15:0] lv);
      bit expired;
      m_pulse = 1'b0;
      expired = 1'b0;
      if (l) begin
         m_secs   = bcd_to_secs(lv);
         m_reload = m_secs;
         m_state  = M_IDLE;
      end else if (m_state == M_RUN) begin
         if (t) begin
            m_secs = m_secs - 1;
            expired = (m_secs == 0);
         end
         if (expired) begin
            m_pulse = 1'b1;
            if (AUTO && m_reload != 0) m_secs = m_reload;
            else m_state = M_DONE;
         end else if (p && !s) begin
            m_state = M_PAUSE;
         end
      end else if ((m_state == M_IDLE || m_state == M_PAUSE) && s) begin
         if (m_secs == 0) begin
            m_state = M_DONE;
            m_pulse = 1'b1;
         end else begin
            m_state = M_RUN;
         end
      end
   endtask

   task automatic compare_all();
      check("digits", digits, secs_to_bcd(m_secs));
      check("running", {15'd0, running}, {15'd0, m_state == M_RUN});
      check("done", {15'd0, done}, {15'd0, m_state == M_DONE});
      check("done_pulse", {15'd0, done_pulse}, {15'd0, m_pulse});
   endtask

   // One clock: drive at negedge, update model at posedge, compare just after
   task automatic cycle(input bit t, input bit s, input bit p, input bit l,
                        input logic [15:0] lv);
      @(negedge clk);
      tick = t; start = s; pause = p; load = l; load_value = lv;
      @(posedge clk);
      model_step(t, s, p, l, lv);
      #1;
      compare_all();
   endtask

   // Short clear pulse between edges: outputs must reset without a clock edge
   task automatic do_clear();
      @(negedge clk);
      tick = 0; start = 0; pause = 0; load = 0;
      clear = 1'b1;
      #2;
      model_reset();
      compare_all();
      check("clear_digits_lit", digits, 16'h0100);
      clear = 1'b0;
   endtask

   initial begin
      clear = 1'b1; tick = 0; start = 0; pause = 0; load = 0; load_value = 16'h0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      check("reset_digits_lit", digits, 16'h0100);
      check("reset_running_lit", {15'd0, running}, 16'd0);
      clear = 1'b0;

      // Start and one tick from 01:00
      cycle(0, 1, 0, 0, 16'h0);
      check("start_running_lit", {15'd0, running}, 16'd1);
      cycle(1, 0, 0, 0, 16'h0);
      check("first_tick_lit", digits, 16'h0059);

      // Count 00:10 to expiry
      cycle(0, 0, 0, 1, 16'h0010);
      cycle(0, 1, 0, 0, 16'h0);
      repeat (9) cycle(1, 0, 0, 0, 16'h0);
      check("nine_ticks_lit", digits, 16'h0001);
      cycle(1, 0, 0, 0, 16'h0);
      check("expire_pulse_lit", {15'd0, done_pulse}, 16'd1);
`ifndef MMSS_TIMER_AUTO_RELOAD_EN
      check("expire_digits_lit", digits, 16'h0000);
      check("expire_done_lit", {15'd0, done}, 16'd1);
      cycle(1, 0, 0, 0, 16'h0);
      check("pulse_one_cycle_lit", {15'd0, done_pulse}, 16'd0);
      cycle(1, 1, 0, 0, 16'h0);
      check("done_holds_lit", digits, 16'h0000);
      check("done_sticky_lit", {15'd0, done}, 16'd1);
`else
      check("reload_digits_lit", digits, 16'h0010);
      check("reload_running_lit", {15'd0, running}, 16'd1);
      cycle(0, 0, 0, 1, 16'h0002);
      cycle(0, 1, 0, 0, 16'h0);
      repeat (2) cycle(1, 0, 0, 0, 16'h0);
      check("auto_digits_lit", digits, 16'h0002);
      check("auto_pulse_lit", {15'd0, done_pulse}, 16'd1);
      check("auto_done_lit", {15'd0, done}, 16'd0);
`endif

      // Multi-digit borrow and sanitising
      cycle(0, 0, 0, 1, 16'h2000);
      cycle(0, 1, 0, 0, 16'h0);
      cycle(1, 0, 0, 0, 16'h0);
      check("borrow_lit", digits, 16'h1959);
      cycle(0, 0, 0, 1, 16'h0A7F);
      check("sanitise_lit", digits, 16'h0959);

      // Tick together with pause
      cycle(0, 0, 0, 1, 16'h0030);
      cycle(0, 1, 0, 0, 16'h0);
      cycle(1, 0, 1, 0, 16'h0);
      check("tick_pause_lit", digits, 16'h0029);
      check("paused_lit", {15'd0, running}, 16'd0);
      repeat (3) cycle(1, 0, 0, 0, 16'h0);
      check("paused_hold_lit", digits, 16'h0029);
      cycle(0, 1, 0, 0, 16'h0);
      check("resume_lit", {15'd0, running}, 16'd1);

      // Clear mid-count, then load beats tick
      cycle(0, 0, 0, 1, 16'h0042);
      cycle(0, 1, 0, 0, 16'h0);
      do_clear();
      cycle(0, 1, 0, 0, 16'h0);
      cycle(1, 0, 0, 1, 16'h0042);
      check("load_beats_tick_lit", digits, 16'h0042);

      // Start at 00:00 goes straight to DONE
      cycle(0, 0, 0, 1, 16'h0000);
      cycle(0, 1, 0, 0, 16'h0);
      check("start_zero_lit", {15'd0, done}, 16'd1);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         bit          t, s, p, l;
         logic [15:0] lv;
         t = ($urandom_range(0, 1) == 1);
         s = ($urandom_range(0, 7) == 0);
         p = ($urandom_range(0, 15) == 0);
         l = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 1) == 1) lv = 16'($urandom);
         else lv = {8'h00, 8'($urandom)};
         if ($urandom_range(0, 299) == 0) do_clear();
         else cycle(t, s, p, l, lv);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mmss_countdown_timer.md
# mmss_countdown_timer

Four-digit BCD minutes:seconds countdown timer consuming the one-cycle enable pulse produced by the rate-divider stage. It sits between the tick source and the seven-segment decoders: it decrements on each tick while running, stops or reloads at 00:00, and presents four BCD digits plus status flags for display and game logic. All state is in the `clk` domain, and all outputs are registered.

## Interface
- `DEFAULT_LOAD`, 16'h0100: BCD value {min_tens, min_ones, sec_tens, sec_ones} used at reset (01:00).
- `clk`  in  1  system clock (CLOCK_50 at top level).
- `clear`  in  1  asynchronous, active-high reset.
- `tick`  in  1  one-cycle enable pulse from the rate divider; counts only while RUNNING.
- `load`  in  1  one-cycle request: capture `load_value` into count and reload register.
- `load_value`  in  16  BCD MM:SS value, sanitised on capture.
- `start`  in  1  one-cycle request: begin or resume counting.
- `pause`  in  1  one-cycle request: suspend counting.
- `digits`  out  16  current count {min_tens, min_ones, sec_tens, sec_ones}, BCD.
- `running`  out  1  high while in RUNNING.
- `done`  out  1  sticky flag, high while in DONE.
- `done_pulse`  out  1  one-cycle pulse when the count expires.

## Operation
- States: IDLE, RUNNING, PAUSED, DONE (2-bit encoding).
- Reset values:
  - state=IDLE; `digits` and reload register = `DEFAULT_LOAD`.
  - `running`=0, `done`=0, `done_pulse`=0.
- Priority per edge: `clear` > `load` > `tick`/`start`/`pause`.
- `load` (any state):
  - count and reload register take the sanitised `load_value`; state goes to IDLE; `done` clears.
  - A `tick`, `start` or `pause` in the same cycle is ignored.
- Sanitising: any ones digit >9 becomes 9; `sec_tens` >5 becomes 5; `min_tens` >9 becomes 9.
- IDLE or PAUSED with `start`:
  - count 00:00 → DONE, with `done_pulse`.
  - Any other count → RUNNING.
- RUNNING with `pause` → PAUSED. `start` and `pause` in the same cycle: no state change; any tick is still applied.
- RUNNING with `tick`: count decrements by one second with BCD borrow:
  - `sec_ones` 0→9, borrowing from `sec_tens`.
  - `sec_tens` 0→5, borrowing from `min_ones`.
  - `min_ones` 0→9, borrowing from `min_tens`.
- Expiry (RUNNING, `tick`, count 00:01): count → 00:00, state → DONE, `done_pulse`=1 for one cycle.
- RUNNING with `tick` and `pause` together: the decrement is applied and the state goes to PAUSED. If that tick expires the count, DONE wins.
- `tick` outside RUNNING: ignored.
- DONE: count holds 00:00; `start`, `pause` and `tick` are ignored. Only `load` or `clear` exits.
- 99:59 is the maximum; decrementing from it needs no special case.

## Timing
- Every output changes only on the `clk` edge that samples the causing input, so latency is 1 cycle from input to output.
- `done_pulse` is high exactly in the cycle after the expiring edge and low otherwise.
- `done` and `running` are decoded from the registered state, so there is no combinational input-to-output path.
- Inputs are assumed synchronous to `clk`; debounce and synchronisation are done upstream.
- `clear` asserted mid-count: all registers take their reset values immediately (asynchronous). Release is used synchronously.

## Configuration
- Macro `MMSS_TIMER_AUTO_RELOAD_EN`.
- Defined: at expiry, the count takes the reload register value instead of 00:00. The state stays RUNNING, `done_pulse` still fires, and `done` stays 0.
  - Exception: if the reload value is 00:00, behaviour matches the undefined case (DONE).
- Undefined: expiry always goes to DONE as described above.

## Structure
- Shared package holds:
  - state typedef (IDLE, RUNNING, PAUSED, DONE);
  - BCD digit-limit constants (9, 5);
  - the 16'h0000 zero constant.
- One natural sub-module, `bcd_down_digit`:
  - parameter MAX (9 or 5); inputs `en` and `load`; outputs `q` and `borrow_out`.
  - Instantiated four times and chained by borrow.
- FSM, sanitising and reload register live in the top.

## Test plan
- Reset with default → `digits`=16'h0100, state IDLE; `start` then 1 tick → 16'h0059, `running`=1.
- Load 16'h0010, start, 10 ticks → `digits`=0000, `done_pulse` high one cycle, `done`=1; further ticks and `start` → no change.
- Load 16'h2000, start, 1 tick → 16'h1959; load 16'h0A7F → captured as 16'h0959.
- Running at 16'h0030, `tick`+`pause` same cycle → 16'h0029 and PAUSED; 3 ticks → still 0029; `start` → RUNNING.
- `clear` pulse while running at 16'h0042 → immediate reset to 16'h0100, IDLE; `load`+`tick` same cycle → loaded value, no decrement.
- With `MMSS_TIMER_AUTO_RELOAD_EN`: load 16'h0002, start, 2 ticks → `digits`=0002, `done_pulse`=1, `running`=1, `done`=0.
